// File: rtl/profile_counter_bank_if.sv
// profile_counter_bank_if: control/readout bundle for the profiling counter bank
// Ports: master drives start/stop/en/clear (per channel), snap and rd_sel, and receives
// rd_count/rd_sess/rd_ovf (registered shadow readout) plus running/overflow (live state).
interface profile_counter_bank_if #(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 32,
    parameter int SESS_WIDTH = 16,
    parameter int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0]     start;
    logic [NUM_CH-1:0]     stop;
    logic [NUM_CH-1:0]     en;
    logic [NUM_CH-1:0]     clear;
    logic                  snap;
    logic [SEL_W-1:0]      rd_sel;
    logic [WIDTH-1:0]      rd_count;
    logic [SESS_WIDTH-1:0] rd_sess;
    logic                  rd_ovf;
    logic [NUM_CH-1:0]     running;
    logic [NUM_CH-1:0]     overflow;
    modport master (
        output start, stop, en, clear, snap, rd_sel,
        input  rd_count, rd_sess, rd_ovf, running, overflow
    );
    modport slave (
        input  start, stop, en, clear, snap, rd_sel,
        output rd_count, rd_sess, rd_ovf, running, overflow
    );
endinterface

// File: rtl/profile_counter_bank.sv
// profile_counter_bank: per-channel cycle/session profiling counters with coherent snapshot readout
// Ports: clk, reset (sync, active-high); bus (slave modport) carries per-channel
// start/stop/en/clear, global snap, rd_sel and the rd_*/running/overflow outputs.
module profile_counter_bank #(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 32,
    parameter int SESS_WIDTH = 16,
    parameter bit SATURATE   = 1'b1
) (
    input logic                   clk,
    input logic                   reset,
    profile_counter_bank_if.slave bus
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // Shadow table padded to the full rd_sel range so out-of-range selects read zero.
    localparam int DEPTH = 1 << SEL_W;

    logic [WIDTH-1:0]      w_sh_cnt  [DEPTH];
    logic [SESS_WIDTH-1:0] w_sh_sess [DEPTH];
    logic [DEPTH-1:0]      w_sh_ovf;
    logic [NUM_CH-1:0]     w_run;
    logic [NUM_CH-1:0]     w_ovf;
    logic [WIDTH-1:0]      r_rd_count;
    logic [SESS_WIDTH-1:0] r_rd_sess;
    logic                  r_rd_ovf;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ch
        if (i < NUM_CH) begin : g_live
            logic                  r_run;
            logic                  r_ovf;
            logic                  r_sh_ovf;
            logic [WIDTH-1:0]      r_cnt;
            logic [WIDTH-1:0]      r_sh_cnt;
            logic [SESS_WIDTH-1:0] r_sess;
            logic [SESS_WIDTH-1:0] r_sh_sess;
            logic                  w_incr;
            logic                  w_done;
            logic                  w_cnt_max;
            logic                  w_sess_max;
            // The start cycle already counts; the stop cycle never does.
            assign w_incr     = (r_run | bus.start[i]) & bus.en[i] & ~bus.stop[i];
            assign w_done     = bus.stop[i] & r_run;
            assign w_cnt_max  = &r_cnt;
            assign w_sess_max = &r_sess;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_run     <= 1'b0;
                    r_cnt     <= '0;
                    r_sess    <= '0;
                    r_ovf     <= 1'b0;
                    r_sh_cnt  <= '0;
                    r_sh_sess <= '0;
                    r_sh_ovf  <= 1'b0;
                end else begin
                    r_run <= ~bus.stop[i] & (r_run | bus.start[i]);
                    // Snapshot takes pre-update values, so it also sees pre-clear state.
                    if (bus.snap) begin
                        r_sh_cnt  <= r_cnt;
                        r_sh_sess <= r_sess;
                        r_sh_ovf  <= r_ovf;
                    end
                    if (bus.clear[i]) begin
                        r_cnt  <= '0;
                        r_sess <= '0;
                        r_ovf  <= 1'b0;
                    end else begin
                        if (w_incr)
                            r_cnt <= (w_cnt_max && SATURATE) ? r_cnt : r_cnt + 1'b1;
                        if (w_done)
                            r_sess <= (w_sess_max && SATURATE) ? r_sess : r_sess + 1'b1;
                        if ((w_incr & w_cnt_max) | (w_done & w_sess_max))
                            r_ovf <= 1'b1;
                    end
                end
            end
            assign w_run[i]     = r_run;
            assign w_ovf[i]     = r_ovf;
            assign w_sh_cnt[i]  = r_sh_cnt;
            assign w_sh_sess[i] = r_sh_sess;
            assign w_sh_ovf[i]  = r_sh_ovf;
        end else begin : g_pad
            assign w_sh_cnt[i]  = '0;
            assign w_sh_sess[i] = '0;
            assign w_sh_ovf[i]  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_count <= '0;
            r_rd_sess  <= '0;
            r_rd_ovf   <= 1'b0;
        end else begin
            r_rd_count <= w_sh_cnt[bus.rd_sel];
            r_rd_sess  <= w_sh_sess[bus.rd_sel];
            r_rd_ovf   <= w_sh_ovf[bus.rd_sel];
        end
    end

    assign bus.running  = w_run;
    assign bus.overflow = w_ovf;
    assign bus.rd_count = r_rd_count;
    assign bus.rd_sess  = r_rd_sess;
    assign bus.rd_ovf   = r_rd_ovf;
endmodule

// File: tb/tb_profile_counter_bank.sv
// tb_profile_counter_bank: table, directed and random checks of saturating and wrapping banks
module tb_profile_counter_bank;
    localparam int NCH  = 5;
    localparam int CMAX = 15;
    localparam int SMAX = 7;

    logic clk = 1'b0;
    logic rst;
    logic [NCH-1:0] st, sp, en, cl;
    logic sn;
    logic [2:0] sel;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    profile_counter_bank_if #(.NUM_CH(NCH), .WIDTH(4), .SESS_WIDTH(3)) if_s ();
    profile_counter_bank_if #(.NUM_CH(NCH), .WIDTH(4), .SESS_WIDTH(3)) if_w ();

    assign if_s.start = st;
    assign if_s.stop = sp;
    assign if_s.en = en;
    assign if_s.clear = cl;
    assign if_s.snap = sn;
    assign if_s.rd_sel = sel;
    assign if_w.start = st;
    assign if_w.stop = sp;
    assign if_w.en = en;
    assign if_w.clear = cl;
    assign if_w.snap = sn;
    assign if_w.rd_sel = sel;

    profile_counter_bank #(.NUM_CH(NCH), .WIDTH(4), .SESS_WIDTH(3), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(rst), .bus(if_s));
    profile_counter_bank #(.NUM_CH(NCH), .WIDTH(4), .SESS_WIDTH(3), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(rst), .bus(if_w));

    logic [NCH-1:0] o_run[2], o_ovf[2];
    logic [3:0] o_rc[2];
    logic [2:0] o_rs[2];
    logic o_ro[2];
    assign o_run[0] = if_s.running;
    assign o_run[1] = if_w.running;
    assign o_ovf[0] = if_s.overflow;
    assign o_ovf[1] = if_w.overflow;
    assign o_rc[0] = if_s.rd_count;
    assign o_rc[1] = if_w.rd_count;
    assign o_rs[0] = if_s.rd_sess;
    assign o_rs[1] = if_w.rd_sess;
    assign o_ro[0] = if_s.rd_ovf;
    assign o_ro[1] = if_w.rd_ovf;

    // Reference model: index 0 = saturating bank, 1 = wrapping bank.
    int m_run[NCH];
    int m_cnt[2][NCH], m_sess[2][NCH], m_ovf[2][NCH];
    int s_cnt[2][NCH], s_sess[2][NCH], s_ovf[2][NCH];
    int m_rc[2], m_rs[2], m_ro[2];

    function automatic void model();
        int inc, done;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_run[c] = 0;
                for (int v = 0; v < 2; v++) begin
                    m_cnt[v][c] = 0; m_sess[v][c] = 0; m_ovf[v][c] = 0;
                    s_cnt[v][c] = 0; s_sess[v][c] = 0; s_ovf[v][c] = 0;
                end
            end
            for (int v = 0; v < 2; v++) begin
                m_rc[v] = 0; m_rs[v] = 0; m_ro[v] = 0;
            end
            return;
        end
        for (int v = 0; v < 2; v++) begin
            m_rc[v] = (sel < NCH) ? s_cnt[v][sel] : 0;
            m_rs[v] = (sel < NCH) ? s_sess[v][sel] : 0;
            m_ro[v] = (sel < NCH) ? s_ovf[v][sel] : 0;
            for (int c = 0; c < NCH; c++) begin
                if (sn) begin
                    s_cnt[v][c] = m_cnt[v][c];
                    s_sess[v][c] = m_sess[v][c];
                    s_ovf[v][c] = m_ovf[v][c];
                end
                inc = ((m_run[c] != 0 || st[c]) && en[c] && !sp[c]) ? 1 : 0;
                done = (sp[c] && m_run[c] != 0) ? 1 : 0;
                if (cl[c]) begin
                    m_cnt[v][c] = 0; m_sess[v][c] = 0; m_ovf[v][c] = 0;
                end else begin
                    if (inc != 0) begin
                        if (m_cnt[v][c] == CMAX) begin
                            m_ovf[v][c] = 1;
                            m_cnt[v][c] = (v == 0) ? CMAX : 0;
                        end else m_cnt[v][c]++;
                    end
                    if (done != 0) begin
                        if (m_sess[v][c] == SMAX) begin
                            m_ovf[v][c] = 1;
                            m_sess[v][c] = (v == 0) ? SMAX : 0;
                        end else m_sess[v][c]++;
                    end
                end
            end
        end
        for (int c = 0; c < NCH; c++) m_run[c] = (!sp[c] && (m_run[c] != 0 || st[c])) ? 1 : 0;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        int er, eo;
        model();
        @(posedge clk);
        #1;
        er = 0;
        for (int c = 0; c < NCH; c++) er |= m_run[c] << c;
        for (int v = 0; v < 2; v++) begin
            eo = 0;
            for (int c = 0; c < NCH; c++) eo |= m_ovf[v][c] << c;
            cmp($sformatf("running[%0d]", v), int'(o_run[v]), er);
            cmp($sformatf("overflow[%0d]", v), int'(o_ovf[v]), eo);
            cmp($sformatf("rd_count[%0d]", v), int'(o_rc[v]), m_rc[v]);
            cmp($sformatf("rd_sess[%0d]", v), int'(o_rs[v]), m_rs[v]);
            cmp($sformatf("rd_ovf[%0d]", v), int'(o_ro[v]), m_ro[v]);
        end
    endtask

    typedef struct {
        logic [NCH-1:0] st, sp, en;
        logic sn;
        logic [2:0] sel;
        logic [NCH-1:0] e_run;
        int e_rc, e_rs;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic [NCH-1:0] a_st, a_sp, a_en, input logic a_sn,
                                input logic [2:0] a_sel, input logic [NCH-1:0] a_run,
                                input int a_rc, a_rs);
        vec_t r;
        r.st = a_st; r.sp = a_sp; r.en = a_en; r.sn = a_sn; r.sel = a_sel;
        r.e_run = a_run; r.e_rc = a_rc; r.e_rs = a_rs;
        return r;
    endfunction

    task automatic idle();
        st = '0; sp = '0; en = '0; cl = '0; sn = 1'b0; sel = '0;
    endtask

    initial begin
        tbl.push_back(mk(5'b00001, 0, 5'b00001, 0, 0, 5'b00001, 0, 0));
        for (int k = 1; k < 10; k++) tbl.push_back(mk(0, 0, 5'b00001, 0, 0, 5'b00001, 0, 0));
        tbl.push_back(mk(0, 5'b00001, 5'b00001, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 10, 1));
        tbl.push_back(mk(5'b00010, 0, 5'b00010, 0, 0, 5'b00010, 10, 1));
        for (int k = 1; k < 8; k++)
            tbl.push_back(mk(0, 0, (k % 2 == 0) ? 5'b00010 : 5'b00000, 0, 0, 5'b00010, 10, 1));
        tbl.push_back(mk(0, 5'b00010, 0, 0, 0, 0, 10, 1));
        tbl.push_back(mk(5'b00010, 5'b00010, 5'b00010, 0, 0, 0, 10, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 4, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 10, 1));
        tbl.push_back(mk(0, 0, 0, 0, 5, 0, 0, 0));

        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        foreach (tbl[k]) begin
            st = tbl[k].st; sp = tbl[k].sp; en = tbl[k].en; sn = tbl[k].sn; sel = tbl[k].sel;
            step();
            cmp($sformatf("tbl%0d_run", k), int'(o_run[0]), int'(tbl[k].e_run));
            cmp($sformatf("tbl%0d_rc", k), int'(o_rc[0]), tbl[k].e_rc);
            cmp($sformatf("tbl%0d_rs", k), int'(o_rs[1]), tbl[k].e_rs);
        end

        // 20 enabled cycles on ch3: saturate holds at 15, wrap lands on 4.
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        st = 5'b01000; en = 5'b01000;
        step();
        st = '0;
        repeat (19) step();
        en = '0; sn = 1'b1; sel = 3'd3;
        step();
        sn = 1'b0;
        step();
        cmp("sat_cnt", int'(o_rc[0]), 15);
        cmp("wrap_cnt", int'(o_rc[1]), 4);
        cmp("sat_rd_ovf", int'(o_ro[0]), 1);
        cmp("wrap_rd_ovf", int'(o_ro[1]), 1);
        cmp("live_ovf3", int'(o_ovf[1][3]), 1);

        // Ch2: 23 counts (wrap -> 7), then snap and clear together.
        st = 5'b00100; en = 5'b00100;
        step();
        st = '0;
        repeat (22) step();
        sn = 1'b1; cl = 5'b00100;
        step();
        sn = 1'b0; cl = '0; sel = 3'd2;
        step();
        cmp("snapclr_wrap_rc", int'(o_rc[1]), 7);
        cmp("snapclr_sat_rc", int'(o_rc[0]), 15);
        cmp("snapclr_rd_ovf", int'(o_ro[1]), 1);
        cmp("snapclr_live_ovf2", int'(o_ovf[1][2]), 0);
        cmp("snapclr_run2", int'(o_run[1][2]), 1);
        step();
        en = '0; sn = 1'b1;
        step();
        sn = 1'b0;
        step();
        cmp("resume_sat_rc", int'(o_rc[0]), 2);
        cmp("resume_wrap_rc", int'(o_rc[1]), 2);
        cmp("resume_rd_ovf", int'(o_ro[0]), 0);

        // Reset in the middle of sessions on every channel.
        st = '1; en = '1;
        step();
        st = '0;
        repeat (3) step();
        sn = 1'b1;
        step();
        sn = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmp("rst_run", int'(o_run[0]), 0);
        cmp("rst_ovf", int'(o_ovf[0]), 0);
        cmp("rst_rc", int'(o_rc[0]), 0);
        en = '0; sp = '1;
        step();
        sp = '0; sn = 1'b1;
        step();
        sn = 1'b0; sel = 3'd4;
        step();
        cmp("rst_sess", int'(o_rs[0]), 0);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            st = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
            sp = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
            en = NCH'($urandom) | NCH'($urandom);
            cl = ($urandom_range(0, 19) == 0) ? NCH'($urandom) : '0;
            sn = ($urandom_range(0, 5) == 0);
            sel = 3'($urandom_range(0, 7));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
